// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock.
// Produces {remainder, quotient} for signed or unsigned WIDTH-bit operands,
// with divide-by-zero shortcut, cancel (annul) and a hold-until-consumed
// result handshake for the EX-stage HI/LO path.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // {partial remainder, dividend/quotient bits}
  logic [WIDTH-1:0]   dvs;      // divisor magnitude
  logic               neg_q;    // quotient needs negation
  logic               neg_r;    // remainder needs negation

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               last;
  logic               accept;

  // Magnitude of an operand: two's negate only when treated as signed and negative.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
    return c ? (~v + 1'b1) : v;
  endfunction

  assign accept = start_i && !annul_i;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step: shift, trial-subtract from the upper part, keep or restore.
  always_comb begin
    shifted = {acc, 1'b0};
    fits    = (shifted[2*WIDTH:WIDTH] >= {1'b0, dvs});
    // Remainder is always below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the trial subtraction fits.
    diff    = shifted[2*WIDTH-1:WIDTH] - dvs;
    acc_nxt = shifted[2*WIDTH-1:0];
    if (fits) begin
      acc_nxt = {diff, shifted[WIDTH-1:1], 1'b1};
    end
  end

  // Next-state logic; annul wins in ON/BYZERO, is ignored in END.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FREE: begin
        if (accept) begin
          state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: state_nxt = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i) begin
          state_nxt = S_FREE;
        end else if (last) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_nxt = S_FREE;
        end
      end
    endcase
  end

  // Control state: FSM, iteration counter and the committed result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_ON && state_nxt == S_ON) ? cnt + CNT_W'(1) : '0;
      if (state == S_ON && state_nxt == S_END) begin
        result_o <= {neg_if(acc_nxt[2*WIDTH-1:WIDTH], neg_r),
                     neg_if(acc_nxt[WIDTH-1:0], neg_q)};
      end else if (state_nxt != S_END) begin
        result_o <= '0;
      end
    end
  end

  // Datapath: latch operand magnitudes on acceptance, then iterate while ON.
  always_ff @(posedge clk) begin
    if (state == S_FREE && accept) begin
      acc   <= {{WIDTH{1'b0}}, mag(opdata1_i, signed_i)};
      dvs   <= mag(opdata2_i, signed_i);
      neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_r <= signed_i && opdata1_i[WIDTH-1];
    end else if (state == S_ON) begin
      acc <= acc_nxt;
    end
  end

  assign ready_o = (state == S_END);
  assign busy_o  = (state == S_ON) || (state == S_BYZERO);

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter (WIDTH=32 and 8)
// against a plain-arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;

  logic        s32, start32, annul32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        ready32, busy32;

  logic        s8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        ready8, busy8;

  int n_tests = 0;
  int n_fail  = 0;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_i(s32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32),
    .ready_o(ready32), .busy_o(busy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8),
    .ready_o(ready8), .busy_o(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign; /0 gives 0.
  function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 0) return 64'd0;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    longint x, y, q, r;
    if (b == 0) return 16'd0;
    x = s ? longint'($signed(a)) : longint'({56'd0, a});
    y = s ? longint'($signed(b)) : longint'({56'd0, b});
    q = x / y;
    r = x % y;
    return {r[7:0], q[7:0]};
  endfunction

  // Full 32-bit transaction with start held; operands scrambled after the start edge.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, bcnt;
    logic [63:0] exp;
    exp = model32(s, a, b);
    s32 = s; a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = $urandom; b32 = $urandom; s32 = ~s;
    lat = 0; bcnt = 0;
    while (!ready32 && lat < 80) begin
      if (busy32) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd32);
    check({tag, " busy"}, 64'(bcnt), (b == 0) ? 64'd1 : 64'd32);
    check({tag, " result"}, res32, exp);
    repeat (2) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, 64'(ready32), 64'd1);
      check({tag, " hold result"}, res32, exp);
    end
    start32 = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, 64'(ready32), 64'd0);
    check({tag, " drop result"}, res32, 64'd0);
  endtask

  // 8-bit transaction with start held `hold` cycles past ready.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input int hold, input string tag);
    int lat;
    logic [15:0] exp;
    exp = model8(s, a, b);
    s8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!ready8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd8);
    check({tag, " result"}, 64'(res8), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " stable"}, {47'd0, ready8, res8}, {47'd1, exp});
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop"}, {47'd0, ready8, res8}, 64'd0);
  endtask

  initial begin
    logic rdy_seen;
    logic [31:0] ra, rb;
    rst = 1'b0;
    s32 = 0; a32 = 0; b32 = 0; start32 = 0; annul32 = 0;
    s8 = 0; a8 = 0; b8 = 0; start8 = 0; annul8 = 0;
    #2;
    check("reset outputs 32", {res32[62:0], ready32} | {63'd0, busy32}, 64'd0);
    check("reset outputs 8", {46'd0, res8, ready8, busy8}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases.
    run32(1'b0, 32'd100, 32'd7, "u100/7");
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7/2");
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, "s7/-2");
    run32(1'b0, 32'h1234, 32'd0, "div0");
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin/-1");
    run32(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, "ubig");

    // Annul at cycle 10 of ON.
    rdy_seen = 1'b0;
    s32 = 0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
      rdy_seen |= ready32;
    end
    annul32 = 1'b1;
    @(posedge clk); #1;
    check("annul busy", 64'(busy32), 64'd0);
    annul32 = 1'b0; start32 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      rdy_seen |= ready32;
    end
    check("annul no ready", 64'(rdy_seen), 64'd0);
    run32(1'b0, 32'd50, 32'd5, "post-annul");

    // Annul in FREE suppresses start.
    start32 = 1'b1; annul32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    @(posedge clk); #1;
    check("annul free busy", 64'(busy32), 64'd0);
    start32 = 1'b0; annul32 = 1'b0;
    @(posedge clk); #1;

    // Annul in END ignored, then async reset while in END.
    s32 = 0; a32 = 32'd20; b32 = 32'd4; start32 = 1'b1;
    @(posedge clk); #1;
    repeat (32) @(posedge clk);
    #1;
    annul32 = 1'b1;
    @(posedge clk); #1;
    check("annul end ready", 64'(ready32), 64'd1);
    check("annul end result", res32, {32'd0, 32'd5});
    annul32 = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("rst end ready", 64'(ready32), 64'd0);
    check("rst end result", res32, 64'd0);
    start32 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Async reset mid-ON.
    s32 = 0; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst on busy", 64'(busy32), 64'd0);
    check("rst on out", {res32[62:0], ready32}, 64'd0);
    start32 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run32(1'b0, 32'd9, 32'd3, "post-reset");

    // Randomized 32-bit operations with corner operands mixed in.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'($urandom_range(0, 200));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run32(1'($urandom_range(0, 1)), ra, rb, "rand32");
    end

    // 8-bit handshake and randomized 8-bit operations.
    run8(1'b1, 8'h80, 8'hFF, 5, "s8 0x80/0xFF");
    for (int i = 0; i < 10; i++) begin
      run8(1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom),
           $urandom_range(0, 3), "rand8");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
